// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus for regfile_write_arbiter: WB request, MDU result handshake,
// register-file write outputs and hazard-unit pending mask.
interface regfile_write_arbiter_if;
  logic        WbRegWrite;
  logic [4:0]  WbA3;
  logic [31:0] WbWD3;
  logic        MdValid;
  logic [4:0]  MdA3;
  logic [31:0] MdWD;
  logic        MdReady;
  logic        StallWB;
  logic        RegWrite;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] MdPending;

  modport master (
    output WbRegWrite, WbA3, WbWD3, MdValid, MdA3, MdWD,
    input  MdReady, StallWB, RegWrite, A3, WD3, MdPending
  );

  modport slave (
    input  WbRegWrite, WbA3, WbWD3, MdValid, MdA3, MdWD,
    output MdReady, StallWB, RegWrite, A3, WD3, MdPending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, MDU results queue in a FIFO.
// Optional starvation guard (forced MDU drain, WB stall): REGWR_STARVE_GUARD_EN.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                    CLK,
  input logic                    RST,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [4:0]       fa3 [DEPTH];
  logic [31:0]      fwd [DEPTH];
  logic [DEPTH-1:0] fvld;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      count;
  logic             full, empty, push, pop, wb_grant, force_drain;
  logic             regwrite_q;
  logic [4:0]       a3_q;
  logic [31:0]      wd3_q;
  logic [31:0]      pend;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push     = bus.MdValid && bus.MdReady && (bus.MdA3 != 5'd0);
  assign wb_grant = !force_drain && bus.WbRegWrite && (bus.WbA3 != 5'd0);
  assign pop      = !empty && (force_drain || !wb_grant);

  assign bus.MdReady   = !full && !RST;
  assign bus.RegWrite  = regwrite_q;
  assign bus.A3        = a3_q;
  assign bus.WD3       = wd3_q;
  assign bus.MdPending = pend;

  always_ff @(posedge CLK) begin
    if (push) begin
      fa3[wr_ptr] <= bus.MdA3;
      fwd[wr_ptr] <= bus.MdWD;
    end
  end

  // push is blocked when full, so push and pop never touch the same slot
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fvld   <= '0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        fvld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        fvld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fvld[i]) pend[fa3[i]] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      regwrite_q <= 1'b0;
      a3_q       <= '0;
      wd3_q      <= '0;
    end else begin
      regwrite_q <= wb_grant || pop;
      if (wb_grant) begin
        a3_q  <= bus.WbA3;
        wd3_q <= bus.WbWD3;
      end else if (pop) begin
        a3_q  <= fa3[rd_ptr];
        wd3_q <= fwd[rd_ptr];
      end
    end
  end

`ifdef REGWR_STARVE_GUARD_EN
  typedef enum logic {NORMAL, FORCE} state_t;

  localparam int unsigned SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LAST_DENY = SW'(STARVE_LIMIT - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;

  assign force_drain = (state_q == FORCE);
  assign bus.StallWB = (state_q == FORCE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // The denial that would bring the count to STARVE_LIMIT moves straight to
  // FORCE, so the stall lands in the cycle right after the LIMIT-th denial.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      NORMAL: begin
        if (pop || empty) begin
          starve_d = '0;
        end else if (wb_grant) begin
          if (starve_q >= LAST_DENY) begin
            state_d  = FORCE;
            starve_d = '0;
          end else begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      FORCE: begin
        state_d  = NORMAL;
        starve_d = '0;
      end
      default: state_d = NORMAL;
    endcase
  end
`else
  assign force_drain = 1'b0;
  assign bus.StallWB = 1'b0;
`endif
endmodule
